seg7_scan_decoder: RTL and testbench

Receive-side counterpart of the BCD-to-7-segment display path. Monitors a multiplexed 7-segment bus (segment lines plus one-hot digit enables), requires each pattern to be stable for a configurable number of cycles, and decodes it back to a BCD digit stored per display position. Used as a display loopback checker and to recover displayed values from an externally driven scan bus.

---
 rtl/seg7_scan_decoder.sv | 143 ++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// Recovers BCD digits from a multiplexed 7-segment scan bus once each pattern has been stable long enough.
// Optional build macro: SEG7_ACTIVE_LOW_EN (common-anode bus, segment and enable lines inverted at the input register).
module seg7_scan_decoder #(
  parameter int DIGITS     = 4,
  parameter int STABLE_CYC = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     an,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     valid,
  output logic                  err,
  output logic                  upd
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_ACCEPT,
    S_HELD
  } state_t;

  localparam logic [7:0] RUN_MAX = 8'(STABLE_CYC);

  logic [6:0]          w_seg_in;
  logic [DIGITS-1:0]   w_an_in;
  logic [6:0]          r_seg, r_seg_d;
  logic [DIGITS-1:0]   r_an, r_an_d;
  logic [7:0]          r_run, w_run_next;
  state_t              r_state, w_state_next;
  logic                w_same, w_run_full, w_onehot, w_accept;
  logic                w_dec_ok, w_blank;
  logic [3:0]          w_bcd;
  logic [4*DIGITS-1:0] r_digits;
  logic [DIGITS-1:0]   r_valid;
  logic                r_err, r_upd;

`ifdef SEG7_ACTIVE_LOW_EN
  assign w_seg_in = ~seg;
  assign w_an_in  = ~an;
`else
  assign w_seg_in = seg;
  assign w_an_in  = an;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg   <= '0;
      r_an    <= '0;
      r_seg_d <= '0;
      r_an_d  <= '0;
    end else begin
      r_seg   <= w_seg_in;
      r_an    <= w_an_in;
      r_seg_d <= r_seg;
      r_an_d  <= r_an;
    end
  end

  assign w_same     = (r_seg == r_seg_d) && (r_an == r_an_d);
  assign w_onehot   = $onehot(r_an);

  // The run length is evaluated one step ahead so the write lands on the edge the window completes.
  always_comb begin
    w_run_next = 8'd1;
    if (w_same) w_run_next = (r_run == RUN_MAX) ? r_run : r_run + 8'd1;
  end

  assign w_run_full = (w_run_next == RUN_MAX);

  always_ff @(posedge clk) begin
    if (rst || clr) r_run <= '0;
    else            r_run <= w_run_next;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) r_state <= S_IDLE;
    else            r_state <= w_state_next;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_HELD: if (!w_same) w_state_next = S_COUNT;
      S_COUNT:        if (w_run_full) w_state_next = w_onehot ? S_ACCEPT : S_HELD;
      S_ACCEPT:       w_state_next = w_same ? S_HELD : S_COUNT;
      default:        w_state_next = S_IDLE;
    endcase
  end

  assign w_accept = (r_state == S_COUNT) && w_run_full && w_onehot;

  always_comb begin
    w_dec_ok = 1'b1;
    w_bcd    = 4'd0;
    case (r_seg)
      7'h3F: w_bcd = 4'd0;
      7'h06: w_bcd = 4'd1;
      7'h5B: w_bcd = 4'd2;
      7'h4F: w_bcd = 4'd3;
      7'h66: w_bcd = 4'd4;
      7'h6D: w_bcd = 4'd5;
      7'h7D: w_bcd = 4'd6;
      7'h07: w_bcd = 4'd7;
      7'h7F: w_bcd = 4'd8;
      7'h6F: w_bcd = 4'd9;
      default: w_dec_ok = 1'b0;
    endcase
  end

  assign w_blank = (r_seg == 7'h00);

  // clr has priority over a same-cycle acceptance, including the err set.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_digits <= '0;
      r_valid  <= '0;
      r_err    <= 1'b0;
      r_upd    <= 1'b0;
    end else begin
      r_upd <= w_accept && w_dec_ok;
      if (w_accept) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (r_an[i]) begin
            r_valid[i] <= w_dec_ok;
            if (w_dec_ok) r_digits[4*i +: 4] <= w_bcd;
          end
        end
        if (!w_dec_ok && !w_blank) r_err <= 1'b1;
      end
    end
  end

  assign digits = r_digits;
  assign valid  = r_valid;
  assign err    = r_err;
  assign upd    = r_upd;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: each accepting stimulus queues the expected upd edge and digit.
module tb_seg7_scan_decoder;

  localparam int DIGITS     = 4;
  localparam int STABLE_CYC = 3;

  typedef struct {
    int         cyc;
    int         pos;
    logic [3:0] bcd;
  } exp_t;

  logic                clk;
  logic                rst;
  logic [6:0]          seg;
  logic [DIGITS-1:0]   an;
  logic                clr;
  logic [4*DIGITS-1:0] digits;
  logic [DIGITS-1:0]   valid;
  logic                err;
  logic                upd;

  int   cyc;
  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];

  logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYC(STABLE_CYC)) dut (
    .clk    (clk),
    .rst    (rst),
    .seg    (seg),
    .an     (an),
    .clr    (clr),
    .digits (digits),
    .valid  (valid),
    .err    (err),
    .upd    (upd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drive one pattern for n rising edges, starting at a falling edge; queue the acceptance if one is due.
  task automatic hold(input logic [DIGITS-1:0] a, input logic [6:0] s, input int n, input bit expect_upd);
    exp_t e;
    an  = a;
    seg = s;
    if (expect_upd) begin
      e.cyc = cyc + 1 + STABLE_CYC;
      e.pos = 0;
      e.bcd = 4'd0;
      for (int i = 0; i < DIGITS; i++) if (a[i]) e.pos = i;
      for (int k = 0; k < 10; k++) if (seg_tbl[k] == s) e.bcd = 4'(k);
      sb_q.push_back(e);
    end
    repeat (n) @(negedge clk);
  endtask

  task automatic check_outs(input string tag, input logic [15:0] d, input logic [3:0] v, input logic e);
    check({tag, "_digits"}, 32'(digits), 32'(d));
    check({tag, "_valid"},  32'(valid),  32'(v));
    check({tag, "_err"},    32'(err),    32'(e));
  endtask

  always @(negedge clk) begin
    if (upd) begin
      if (sb_q.size() == 0) begin
        check("upd_unexpected", 32'(upd), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("upd_cycle", 32'(cyc), 32'(e.cyc));
        check("upd_digit", 32'(digits[4*e.pos +: 4]), 32'(e.bcd));
        check("upd_valid", 32'(valid[e.pos]), 32'd1);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    clr = 1'b0;
    seg = '0;
    an  = '0;
    repeat (2) @(negedge clk);
    check_outs("reset", 16'h0000, 4'b0000, 1'b0);
    check("reset_upd", 32'(upd), 32'd0);
    rst = 1'b0;

    // Single digit, then a long hold that must not re-accept.
    hold(4'b0001, 7'h5B, 3, 1'b1);
    hold(4'b0001, 7'h5B, 10, 1'b0);
    check_outs("single", 16'h0002, 4'b0001, 1'b0);

    // Back-to-back scan of all positions.
    hold(4'b0001, 7'h4F, 3, 1'b1);
    hold(4'b0010, 7'h07, 3, 1'b1);
    hold(4'b0100, 7'h6F, 3, 1'b1);
    hold(4'b1000, 7'h3F, 3, 1'b1);
    hold(4'b1000, 7'h3F, 2, 1'b0);
    check_outs("scan", 16'h0973, 4'b1111, 1'b0);

    // One-cycle glitch restarts the run.
    hold(4'b0010, 7'h7F, 2, 1'b0);
    hold(4'b0010, 7'h7E, 1, 1'b0);
    hold(4'b0010, 7'h7F, 3, 1'b1);
    hold(4'b0010, 7'h7F, 2, 1'b0);
    check_outs("glitch", 16'h0983, 4'b1111, 1'b0);

    // Invalid pattern sets err and drops valid for that slot.
    hold(4'b0100, 7'h49, 3, 1'b0);
    hold(4'b0100, 7'h49, 2, 1'b0);
    check_outs("invalid", 16'h0983, 4'b1011, 1'b1);

    // clr coincides with the acceptance edge of a valid digit.
    hold(4'b0001, 7'h06, 3, 1'b0);
    clr = 1'b1;
    hold(4'b0001, 7'h06, 1, 1'b0);
    clr = 1'b0;
    hold(4'b0001, 7'h06, 4, 1'b0);
    check_outs("clr", 16'h0000, 4'b0000, 1'b0);

    // Non one-hot enables are ignored.
    hold(4'b0011, 7'h06, 5, 1'b0);
    check_outs("multi_an", 16'h0000, 4'b0000, 1'b0);

    // Blank after a valid digit clears valid but leaves err alone.
    hold(4'b0001, 7'h6D, 3, 1'b1);
    hold(4'b0001, 7'h6D, 1, 1'b0);
    check_outs("digit5", 16'h0005, 4'b0001, 1'b0);
    hold(4'b0100, 7'h49, 4, 1'b0);
    check_outs("err_set", 16'h0005, 4'b0001, 1'b1);
    hold(4'b0001, 7'h00, 4, 1'b0);
    check_outs("blank", 16'h0005, 4'b0000, 1'b1);

    // Reset mid-run discards the partial window.
    hold(4'b0010, 7'h5B, 2, 1'b0);
    rst = 1'b1;
    hold(4'b0010, 7'h5B, 1, 1'b0);
    rst = 1'b0;
    hold(4'b0010, 7'h5B, 3, 1'b1);
    hold(4'b0010, 7'h5B, 2, 1'b0);
    check_outs("rst_mid", 16'h0020, 4'b0010, 1'b0);

    check("pending_upd", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
